// File: rtl/watch_ctrl_pkg.sv
// rtl/watch_ctrl_pkg.sv - shared encodings and command codes for the watch/stopwatch control block
// Contents: stopwatch and watch FSM state types, UART command byte codes,
// default set-mode timeout values.
package watch_ctrl_pkg;

  typedef enum logic [1:0] {
    SW_STOP  = 2'd0,
    SW_RUN   = 2'd1,
    SW_CLEAR = 2'd2
  } sw_state_t;

  // The watch state value doubles as the o_set_field encoding.
  typedef enum logic [1:0] {
    W_NORMAL   = 2'd0,
    W_SET_HOUR = 2'd1,
    W_SET_MIN  = 2'd2,
    W_SET_SEC  = 2'd3
  } w_state_t;

  localparam logic [7:0] CMD_RUN   = 8'h52;  // 'R'
  localparam logic [7:0] CMD_CLEAR = 8'h43;  // 'C'
  localparam logic [7:0] CMD_MODE  = 8'h4D;  // 'M'
  localparam logic [7:0] CMD_SEL   = 8'h53;  // 'S'
  localparam logic [7:0] CMD_UP    = 8'h55;  // 'U'
  localparam logic [7:0] CMD_DOWN  = 8'h44;  // 'D'

  localparam int SET_TIMEOUT_DEFAULT = 1000;
  localparam int TO_BITWIDTH_DEFAULT = 10;

endpackage

// File: rtl/ctrl_event_decode.sv
// rtl/ctrl_event_decode.sv - merges buttons and UART commands into one prioritised event
// Purpose: combinational merge of button pulses and decoded command bytes,
// routed by sw_watch and reduced to at most one active event.
// Ports:
//   sw_watch            1 = watch events (SEL/UP/DOWN), 0 = stopwatch events (RUN/CLEAR/MODE)
//   btn_run/clear/mode  1-cycle button pulses
//   cmd_valid/cmd_data  UART byte strobe and value
//   ev_*                one-hot (or all-zero) event outputs
module ctrl_event_decode
  import watch_ctrl_pkg::*;
(
  input  logic       sw_watch,
  input  logic       btn_run,
  input  logic       btn_clear,
  input  logic       btn_mode,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       ev_run,
  output logic       ev_clear,
  output logic       ev_mode,
  output logic       ev_sel,
  output logic       ev_up,
  output logic       ev_down
);

  logic raw_run, raw_clear, raw_mode, raw_sel, raw_up, raw_down;

  // The same physical button serves a stopwatch function or a watch function
  // depending on sw_watch; OR-ing button and command folds duplicates into one event.
  always_comb begin
    raw_run   = !sw_watch && (btn_run   || (cmd_valid && cmd_data == CMD_RUN));
    raw_clear = !sw_watch && (btn_clear || (cmd_valid && cmd_data == CMD_CLEAR));
    raw_mode  = !sw_watch && (btn_mode  || (cmd_valid && cmd_data == CMD_MODE));
    raw_sel   =  sw_watch && (btn_run   || (cmd_valid && cmd_data == CMD_SEL));
    raw_up    =  sw_watch && (btn_clear || (cmd_valid && cmd_data == CMD_UP));
    raw_down  =  sw_watch && (btn_mode  || (cmd_valid && cmd_data == CMD_DOWN));
  end

  // CLEAR > RUN > MODE and SEL > UP > DOWN.
  always_comb begin
    ev_clear = raw_clear;
    ev_run   = raw_run && !raw_clear;
    ev_mode  = raw_mode && !raw_clear && !raw_run;
    ev_sel   = raw_sel;
    ev_up    = raw_up && !raw_sel;
    ev_down  = raw_down && !raw_sel && !raw_up;
  end

endmodule

// File: rtl/watch_stopwatch_ctrl.sv
// rtl/watch_stopwatch_ctrl.sv - stopwatch run/clear/mode FSM and watch time-set FSM
// Purpose: turns merged button/UART events into stopwatch controls and
// watch set-mode field select with increment/decrement pulses.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   i_tick                  100 Hz single-cycle tick (drives set-mode timeout)
//   i_sw_watch              1 = watch control, 0 = stopwatch control
//   i_btn_run/clear/mode    button pulses
//   i_cmd_valid/i_cmd_data  UART command byte
//   o_sw_run_stop/clear/mode  stopwatch controls
//   o_watch_run             watch chain enable (0 while setting)
//   o_set_field             0 none, 1 hour, 2 min, 3 sec
//   o_set_inc/o_set_dec     1-cycle field adjust pulses
module watch_stopwatch_ctrl
  import watch_ctrl_pkg::*;
#(
  parameter int SET_TIMEOUT = SET_TIMEOUT_DEFAULT,
  parameter int TO_BITWIDTH = TO_BITWIDTH_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tick,
  input  logic       i_sw_watch,
  input  logic       i_btn_run,
  input  logic       i_btn_clear,
  input  logic       i_btn_mode,
  input  logic       i_cmd_valid,
  input  logic [7:0] i_cmd_data,
  output logic       o_sw_run_stop,
  output logic       o_sw_clear,
  output logic       o_sw_mode,
  output logic       o_watch_run,
  output logic [1:0] o_set_field,
  output logic       o_set_inc,
  output logic       o_set_dec
);

  localparam logic [TO_BITWIDTH-1:0] TO_LAST = TO_BITWIDTH'(SET_TIMEOUT - 1);

  logic ev_run, ev_clear, ev_mode, ev_sel, ev_up, ev_down;

  ctrl_event_decode u_decode (
    .sw_watch  (i_sw_watch),
    .btn_run   (i_btn_run),
    .btn_clear (i_btn_clear),
    .btn_mode  (i_btn_mode),
    .cmd_valid (i_cmd_valid),
    .cmd_data  (i_cmd_data),
    .ev_run    (ev_run),
    .ev_clear  (ev_clear),
    .ev_mode   (ev_mode),
    .ev_sel    (ev_sel),
    .ev_up     (ev_up),
    .ev_down   (ev_down)
  );

  sw_state_t              sw_state, sw_next;
  logic                   mode_next;
  w_state_t               w_state, w_next;
  logic [TO_BITWIDTH-1:0] to_cnt, to_cnt_next;
  logic                   inc_next, dec_next;

  // Stopwatch FSM next state. It ignores i_sw_watch directly; routing in the
  // decoder already suppresses its events while the watch is selected.
  always_comb begin
    sw_next   = sw_state;
    mode_next = o_sw_mode;
    case (sw_state)
      SW_STOP: begin
        if (ev_clear)     sw_next = SW_CLEAR;
        else if (ev_run)  sw_next = SW_RUN;
        else if (ev_mode) mode_next = !o_sw_mode;
      end
      SW_RUN: begin
        // A simultaneous CLEAR masks RUN in the decoder and is then ignored here.
        if (ev_run) sw_next = SW_STOP;
      end
      SW_CLEAR: sw_next = SW_STOP;
      default:  sw_next = SW_STOP;
    endcase
  end

  // Watch FSM and set-mode inactivity timeout.
  always_comb begin
    w_next      = w_state;
    to_cnt_next = to_cnt;
    inc_next    = 1'b0;
    dec_next    = 1'b0;
    if (w_state != W_NORMAL && !i_sw_watch) begin
      w_next      = W_NORMAL;
      to_cnt_next = '0;
    end else if (ev_sel) begin
      to_cnt_next = '0;
      case (w_state)
        W_NORMAL:   w_next = W_SET_HOUR;
        W_SET_HOUR: w_next = W_SET_MIN;
        W_SET_MIN:  w_next = W_SET_SEC;
        default:    w_next = W_NORMAL;
      endcase
    end else if (w_state != W_NORMAL) begin
      // User activity takes precedence over a coincident timeout tick.
      if (ev_up) begin
        inc_next    = 1'b1;
        to_cnt_next = '0;
      end else if (ev_down) begin
        dec_next    = 1'b1;
        to_cnt_next = '0;
      end else if (i_tick) begin
        if (to_cnt == TO_LAST) begin
          w_next      = W_NORMAL;
          to_cnt_next = '0;
        end else begin
          to_cnt_next = to_cnt + TO_BITWIDTH'(1);
        end
      end
    end
  end

  // Outputs are registered from next-state values so each event shows up
  // exactly one edge after it is sampled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_state      <= SW_STOP;
      w_state       <= W_NORMAL;
      to_cnt        <= '0;
      o_sw_run_stop <= 1'b0;
      o_sw_clear    <= 1'b0;
      o_sw_mode     <= 1'b0;
      o_watch_run   <= 1'b1;
      o_set_field   <= 2'd0;
      o_set_inc     <= 1'b0;
      o_set_dec     <= 1'b0;
    end else begin
      sw_state      <= sw_next;
      w_state       <= w_next;
      to_cnt        <= to_cnt_next;
      o_sw_run_stop <= (sw_next == SW_RUN);
      o_sw_clear    <= (sw_next == SW_CLEAR);
      o_sw_mode     <= mode_next;
      o_watch_run   <= (w_next == W_NORMAL);
      o_set_field   <= w_next;
      o_set_inc     <= inc_next;
      o_set_dec     <= dec_next;
    end
  end

endmodule

// File: tb/tb_watch_stopwatch_ctrl.sv
// tb/tb_watch_stopwatch_ctrl.sv - directed self-checking bench for watch_stopwatch_ctrl
module tb_watch_stopwatch_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       i_tick, i_sw_watch, i_btn_run, i_btn_clear, i_btn_mode, i_cmd_valid;
  logic [7:0] i_cmd_data;
  logic       o_sw_run_stop, o_sw_clear, o_sw_mode, o_watch_run, o_set_inc, o_set_dec;
  logic [1:0] o_set_field;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  watch_stopwatch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .i_tick        (i_tick),
    .i_sw_watch    (i_sw_watch),
    .i_btn_run     (i_btn_run),
    .i_btn_clear   (i_btn_clear),
    .i_btn_mode    (i_btn_mode),
    .i_cmd_valid   (i_cmd_valid),
    .i_cmd_data    (i_cmd_data),
    .o_sw_run_stop (o_sw_run_stop),
    .o_sw_clear    (o_sw_clear),
    .o_sw_mode     (o_sw_mode),
    .o_watch_run   (o_watch_run),
    .o_set_field   (o_set_field),
    .o_set_inc     (o_set_inc),
    .o_set_dec     (o_set_dec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    i_tick = 0; i_btn_run = 0; i_btn_clear = 0; i_btn_mode = 0;
    i_cmd_valid = 0; i_cmd_data = 8'h00;
  endtask

  // Inputs set before the call are sampled at the next edge, then cleared.
  task automatic step();
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic send_cmd(input logic [7:0] b);
    i_cmd_valid = 1; i_cmd_data = b;
    step();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) begin
      i_tick = 1; step();
      step();
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_run_stop"},  o_sw_run_stop, 0);
    check({tag, "_clear"},     o_sw_clear, 0);
    check({tag, "_mode"},      o_sw_mode, 0);
    check({tag, "_watch_run"}, o_watch_run, 1);
    check({tag, "_field"},     o_set_field, 0);
    check({tag, "_inc"},       o_set_inc, 0);
    check({tag, "_dec"},       o_set_dec, 0);
  endtask

  initial begin
    idle_inputs();
    i_sw_watch = 0;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    check_reset_values("rst");

    // 1: run toggle
    i_btn_run = 1; step();
    check("t1_run_on", o_sw_run_stop, 1);
    i_btn_run = 1; step();
    check("t1_run_off", o_sw_run_stop, 0);

    // mode toggle via button then UART
    i_btn_mode = 1; step();
    check("mode_down", o_sw_mode, 1);
    send_cmd(8'h4D);
    check("mode_up", o_sw_mode, 0);

    // 2: clear pulse in STOP, ignored in RUN
    send_cmd(8'h43);
    check("t2_clear_hi", o_sw_clear, 1);
    step();
    check("t2_clear_lo", o_sw_clear, 0);
    send_cmd(8'h52);
    check("t2_running", o_sw_run_stop, 1);
    send_cmd(8'h43);
    check("t2_clear_ignored", o_sw_clear, 0);
    check("t2_still_run", o_sw_run_stop, 1);
    i_btn_run = 1; step();
    check("t2_stopped", o_sw_run_stop, 0);

    // 3: watch set sequencing
    i_sw_watch = 1;
    i_btn_clear = 1; step();
    check("t3_up_in_normal", o_set_inc, 0);
    i_btn_run = 1; step();
    check("t3_field1", o_set_field, 1);
    check("t3_sw_untouched", o_sw_run_stop, 0);
    send_cmd(8'h53);
    check("t3_field2", o_set_field, 2);
    check("t3_watch_halt", o_watch_run, 0);
    send_cmd(8'h55);
    check("t3_inc_hi", o_set_inc, 1);
    check("t3_inc_nodec", o_set_dec, 0);
    step();
    check("t3_inc_lo", o_set_inc, 0);
    i_btn_mode = 1; step();
    check("t3_dec_hi", o_set_dec, 1);
    step();
    check("t3_dec_lo", o_set_dec, 0);
    // SEL beats UP in the same cycle
    i_btn_run = 1; i_btn_clear = 1; step();
    check("t3_sel_prio_field", o_set_field, 3);
    check("t3_sel_prio_inc", o_set_inc, 0);
    i_btn_run = 1; step();
    check("t3_field0", o_set_field, 0);
    check("t3_watch_run", o_watch_run, 1);

    // 4: timeout
    i_btn_run = 1; step();
    check("t4_enter", o_set_field, 1);
    ticks(999);
    check("t4_999", o_set_field, 1);
    ticks(1);
    check("t4_exit", o_set_field, 0);
    check("t4_exit_run", o_watch_run, 1);
    i_btn_run = 1; step();
    ticks(499);
    i_tick = 1; i_btn_clear = 1; step();
    check("t4_up_at_500", o_set_inc, 1);
    step();
    ticks(999);
    check("t4_1499", o_set_field, 1);
    ticks(1);
    check("t4_1500", o_set_field, 0);

    // 5: CLEAR beats RUN; invalid byte ignored
    i_sw_watch = 0;
    i_btn_run = 1; i_cmd_valid = 1; i_cmd_data = 8'h43; step();
    check("t5_clear_wins", o_sw_clear, 1);
    check("t5_no_run", o_sw_run_stop, 0);
    step();
    send_cmd(8'h58);
    check("t5_bad_run", o_sw_run_stop, 0);
    check("t5_bad_clear", o_sw_clear, 0);
    check("t5_bad_mode", o_sw_mode, 0);
    i_sw_watch = 1;
    send_cmd(8'h58);
    check("t5_bad_field", o_set_field, 0);

    // 6: reset mid-operation, forced exit
    i_sw_watch = 0;
    i_btn_run = 1; step();
    check("t6_running", o_sw_run_stop, 1);
    i_sw_watch = 1;
    i_btn_run = 1; step();
    i_btn_run = 1; step();
    check("t6_in_min", o_set_field, 2);
    i_cmd_valid = 1; i_cmd_data = 8'h55;
    reset = 1;
    #1;
    check_reset_values("t6_async");
    @(posedge clk); #1;
    idle_inputs();
    reset = 0;
    check_reset_values("t6_held");
    i_btn_run = 1; step();
    check("t6_field1", o_set_field, 1);
    i_sw_watch = 0; i_cmd_valid = 1; i_cmd_data = 8'h55; step();
    check("t6_forced_field", o_set_field, 0);
    check("t6_forced_run", o_watch_run, 1);
    check("t6_forced_noinc", o_set_inc, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
